fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_VEC, default 32'h0000_0000, meaning the PC value driven during and after reset.
REQ-002 SHALL have parameter PC_STEP, default 32'd4, meaning the sequential PC increment.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a one-cycle pulse that begins fetching from IDLE.
REQ-006 SHALL have port halt_req, input, 1, which stops fetching after the current access.
REQ-007 SHALL have port stall, input, 1, which holds the PC (decode backpressure).
REQ-008 SHALL have ports br_taken (input, 1) and br_target (input, 32), the branch redirect.
REQ-009 SHALL have ports jmp (input, 1) and jmp_target (input, 32), the jump redirect.
REQ-010 SHALL have port pc_cur, input, 32, the current program-counter register output.
REQ-011 SHALL have port pc_next, output, 32, the value loaded into the program-counter register every clock.
REQ-012 SHALL have ports imem_req (output, 1), imem_addr (output, 32) and imem_ready (input, 1), the instruction-memory handshake.
REQ-013 SHALL have port instr_valid, output, 1, which marks a non-squashed completed fetch.
REQ-014 SHALL have ports fetch_cnt (output, 32) and state_o (output, 2).

Function
REQ-015 SHALL implement the states IDLE=0, FETCH=1, WAIT=2 and HALTED=3.
REQ-016 SHALL drive pc_next = pc_cur in every cycle that does not advance; the program-counter register has no enable.
REQ-017 SHALL transition IDLE->FETCH on start and otherwise hold in IDLE; pc_next = RESET_VEC while in IDLE.
REQ-018 SHALL, in FETCH and WAIT, drive imem_req=1 and imem_addr=pc_cur; imem_req SHALL be 0 in IDLE and HALTED.
REQ-019 SHALL complete an access in any cycle with imem_req=1 and imem_ready=1 (zero-wait completion in FETCH is allowed).
REQ-020 SHALL transition FETCH->WAIT when imem_ready=0, and SHALL hold in WAIT until imem_ready=1.
REQ-021 SHALL select next-PC at completion using priority halt_req > jmp > br_taken > stall > sequential.
REQ-022 SHALL compute sequential next-PC as pc_cur+PC_STEP modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
REQ-023 SHALL, on halt_req at completion, hold the PC, assert instr_valid, and enter HALTED; HALTED SHALL be left only by reset.
REQ-024 SHALL, on stall at completion, hold the PC and assert instr_valid, so the same address is re-fetched.
REQ-025 SHALL latch a jmp or br_taken asserted while in WAIT into a pending-redirect register, with jmp taking priority over br_taken.
REQ-026 SHALL, at completion with a pending redirect, load the pending target, force instr_valid=0 (squash) and clear the pending register.
REQ-027 SHALL raise instr_valid for exactly one cycle per completion and never without a completion.
REQ-028 SHALL increment fetch_cnt on each completion with instr_valid=1, saturating at 32'hFFFF_FFFF.
REQ-029 SHALL drive state_o with the encoding of the current state.

Reset
REQ-030 SHALL, while rst=0, asynchronously force state=IDLE, pending redirect cleared, fetch_cnt=0, instr_valid=0, imem_req=0 and pc_next=RESET_VEC.
REQ-031 SHALL, on reset during WAIT, abandon the outstanding access and ignore any imem_ready that follows.

Structure
REQ-032 SHALL take the state encodings and the default PC_STEP from the shared CPU package.
REQ-033 SHALL contain one sub-module, pc_next_mux, a combinational priority selector for the next-PC value.

Verification
REQ-034 SHALL verify sequential fetch: start with imem_ready=1 constantly -> pc_next = 0,4,8,…, instr_valid=1 each cycle, and fetch_cnt=3 after three cycles.
REQ-035 SHALL verify wait states: imem_ready low for 2 cycles at PC=8 -> state FETCH,WAIT,WAIT; pc_next=8 held; a single instr_valid pulse; then pc_next=12.
REQ-036 SHALL verify redirect during WAIT: br_taken with target 0x40 while in WAIT -> completion squashed (instr_valid=0) and pc_next=0x40.
REQ-037 SHALL verify priority: jmp (target 0x100) and br_taken (target 0x80) together at completion -> pc_next=0x100.
REQ-038 SHALL verify wrap-around: pc_cur=32'hFFFF_FFFC at completion -> pc_next=0.
REQ-039 SHALL verify halt and reset: halt_req -> HALTED, imem_req=0, PC held; then rst=0 mid-cycle -> IDLE and pc_next=0 immediately.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared CPU definitions for the fetch front end: sequencer state encoding,
// default PC increment and the pending-redirect record.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HALTED = 2'd3
  } fs_state_e;

  localparam logic [31:0] PC_STEP_DEF = 32'd4;

  typedef struct packed {
    logic        vld;
    logic [31:0] tgt;
  } redir_t;

endpackage

// File: rtl/fetch_sequencer_pc_next_mux.sv
// Combinational next-PC priority selector:
// halt > pending redirect > jmp > branch > stall > sequential.
module pc_next_mux
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP   = PC_STEP_DEF
) (
  input  logic        i_idle,
  input  logic        i_cpl,
  input  logic        i_halt,
  input  redir_t      i_pend,
  input  logic        i_jmp,
  input  logic [31:0] i_jmp_tgt,
  input  logic        i_br,
  input  logic [31:0] i_br_tgt,
  input  logic        i_stall,
  input  logic [31:0] i_pc_cur,
  output logic [31:0] o_pc_next
);

  // The PC register has no enable, so every non-advancing cycle recirculates pc_cur.
  always_comb begin
    o_pc_next = i_pc_cur;
    if (i_idle) begin
      o_pc_next = RESET_VEC;
    end else if (i_cpl) begin
      if (i_halt)        o_pc_next = i_pc_cur;
      else if (i_pend.vld) o_pc_next = i_pend.tgt;
      else if (i_jmp)    o_pc_next = i_jmp_tgt;
      else if (i_br)     o_pc_next = i_br_tgt;
      else if (i_stall)  o_pc_next = i_pc_cur;
      else               o_pc_next = i_pc_cur + PC_STEP;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives the imem handshake, tracks redirects that
// arrive while an access is outstanding, and computes the next PC every clock.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP   = PC_STEP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt_req,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  output logic        instr_valid,
  output logic [31:0] fetch_cnt,
  output logic [1:0]  state_o
);

  fs_state_e   r_state, w_state_nxt;
  redir_t      r_pend, w_pend_nxt;
  logic [31:0] r_fetch_cnt;
  logic        w_req, w_cpl, w_valid;

  assign w_req = (r_state == ST_FETCH) || (r_state == ST_WAIT);
  assign w_cpl = w_req && imem_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_pend      <= '0;
      r_fetch_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      if (w_valid && (r_fetch_cnt != '1))
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_valid     = 1'b0;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_FETCH;
      ST_FETCH, ST_WAIT: begin
        if (w_cpl) begin
          // A fetch completing behind a latched redirect is on the wrong path.
          w_valid     = halt_req || !r_pend.vld;
          w_pend_nxt  = '0;
          w_state_nxt = halt_req ? ST_HALTED : ST_FETCH;
        end else begin
          w_state_nxt = ST_WAIT;
          // Also latch on the FETCH->WAIT cycle so no redirect is lost.
          if (jmp)                         w_pend_nxt = '{vld: 1'b1, tgt: jmp_target};
          else if (br_taken && !r_pend.vld) w_pend_nxt = '{vld: 1'b1, tgt: br_target};
        end
      end
      default: w_state_nxt = ST_HALTED;
    endcase
  end

  pc_next_mux #(
    .RESET_VEC (RESET_VEC),
    .PC_STEP   (PC_STEP)
  ) u_pc_mux (
    .i_idle    (r_state == ST_IDLE),
    .i_cpl     (w_cpl),
    .i_halt    (halt_req),
    .i_pend    (r_pend),
    .i_jmp     (jmp),
    .i_jmp_tgt (jmp_target),
    .i_br      (br_taken),
    .i_br_tgt  (br_target),
    .i_stall   (stall),
    .i_pc_cur  (pc_cur),
    .o_pc_next (pc_next)
  );

  assign imem_req    = w_req;
  assign imem_addr   = pc_cur;
  assign instr_valid = w_valid;
  assign fetch_cnt   = r_fetch_cnt;
  assign state_o     = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with an abstract reference model and
// per-cycle literal expectations keyed by a stimulus tag.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, halt_req = 1'b0, stall = 1'b0;
  logic        br_taken = 1'b0, jmp = 1'b0;
  logic [31:0] br_target = '0, jmp_target = '0;
  logic [31:0] pc_cur;
  logic [31:0] pc_next, imem_addr, fetch_cnt;
  logic        imem_req, imem_ready = 1'b1, instr_valid;
  logic [1:0]  state_o;

  int n_vec = 0;
  int n_err = 0;
  int tag   = 0;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .stall(stall),
    .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target),
    .pc_cur(pc_cur), .pc_next(pc_next), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .instr_valid(instr_valid), .fetch_cnt(fetch_cnt),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  // External program-counter register: loads pc_next every clock.
  always @(posedge clk or negedge rst)
    if (!rst) pc_cur <= 32'h0; else pc_cur <= pc_next;

  // Reference model: mode 0 idle, 1 issuing, 2 waiting, 3 halted.
  int          m_mode = 0, m_mode_n = 0;
  bit          m_pv = 0, m_pv_n = 0;
  logic [31:0] m_pt = '0, m_pt_n = '0;
  longint      m_cnt = 0, m_cnt_n = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; m_pv = 0; m_pt = '0; m_cnt = 0;
    end else begin
      m_mode = m_mode_n; m_pv = m_pv_n; m_pt = m_pt_n; m_cnt = m_cnt_n;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t tag=%0d)", name, act, exp, $time, tag);
    end
  endtask

  initial begin
    forever begin
      bit          busy, done, ev;
      logic [31:0] epc;
      @(negedge clk or negedge rst);
      #1;
      if (!rst) begin
        chk("rst_pc_next", pc_next, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_cnt", fetch_cnt, 32'h0);
        chk("rst_state", {30'b0, state_o}, 32'h0);
        m_mode_n = 0; m_pv_n = 0; m_pt_n = '0; m_cnt_n = 0;
      end else begin
        busy = (m_mode == 1) || (m_mode == 2);
        done = busy && imem_ready;
        if (m_mode == 0)        epc = 32'h0;
        else if (!done)         epc = pc_cur;
        else if (halt_req)      epc = pc_cur;
        else if (m_pv)          epc = m_pt;
        else if (jmp)           epc = jmp_target;
        else if (br_taken)      epc = br_target;
        else if (stall)         epc = pc_cur;
        else                    epc = pc_cur + 32'd4;
        ev = done && (halt_req || !m_pv);
        chk("pc_next", pc_next, epc);
        chk("imem_req", {31'b0, imem_req}, {31'b0, busy});
        if (busy) chk("imem_addr", imem_addr, pc_cur);
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, ev});
        chk("fetch_cnt", fetch_cnt, m_cnt[31:0]);
        chk("state_o", {30'b0, state_o}, m_mode[31:0]);
        m_cnt_n = (ev && m_cnt < 64'hFFFF_FFFF) ? m_cnt + 1 : m_cnt;
        m_pv_n = m_pv; m_pt_n = m_pt;
        case (m_mode)
          0: m_mode_n = start ? 1 : 0;
          1, 2: begin
            if (done) begin
              m_mode_n = halt_req ? 3 : 1;
              m_pv_n = 0;
            end else begin
              m_mode_n = 2;
              if (jmp) begin m_pv_n = 1; m_pt_n = jmp_target; end
              else if (br_taken && !m_pv) begin m_pv_n = 1; m_pt_n = br_target; end
            end
          end
          default: m_mode_n = 3;
        endcase
      end
      // Hand-computed expectations for specific directed cycles.
      case (tag)
        1:  begin chk("L_idle_state", {30'b0, state_o}, 32'd0); chk("L_idle_pc", pc_next, 32'h0); end
        2:  begin chk("L_seq0_pc", pc_next, 32'h4); chk("L_seq0_valid", {31'b0, instr_valid}, 32'd1); end
        3:  chk("L_seq1_pc", pc_next, 32'h8);
        4:  begin chk("L_seq2_pc", pc_next, 32'hC); chk("L_seq2_cnt", fetch_cnt, 32'd2); end
        5:  begin chk("L_cnt3", fetch_cnt, 32'd3); chk("L_jmp8", pc_next, 32'h8); end
        6:  begin chk("L_w0_state", {30'b0, state_o}, 32'd1); chk("L_w0_pc", pc_next, 32'h8);
                  chk("L_w0_valid", {31'b0, instr_valid}, 32'd0); end
        7:  begin chk("L_w1_state", {30'b0, state_o}, 32'd2); chk("L_w1_pc", pc_next, 32'h8); end
        8:  begin chk("L_w2_state", {30'b0, state_o}, 32'd2); chk("L_w2_valid", {31'b0, instr_valid}, 32'd1);
                  chk("L_w2_pc", pc_next, 32'hC); end
        10: begin chk("L_br_state", {30'b0, state_o}, 32'd2); chk("L_br_hold", pc_next, 32'hC); end
        11: begin chk("L_squash", {31'b0, instr_valid}, 32'd0); chk("L_redir", pc_next, 32'h40);
                  chk("L_squash_cnt", fetch_cnt, 32'd5); end
        12: chk("L_prio", pc_next, 32'h100);
        13: chk("L_jmp_top", pc_next, 32'hFFFF_FFFC);
        14: begin chk("L_wrap", pc_next, 32'h0); chk("L_wrap_valid", {31'b0, instr_valid}, 32'd1); end
        15: begin chk("L_stall_pc", pc_next, 32'h0); chk("L_stall_valid", {31'b0, instr_valid}, 32'd1); end
        17: begin chk("L_halt_pc", pc_next, 32'h4); chk("L_halt_valid", {31'b0, instr_valid}, 32'd1); end
        18: begin chk("L_halted", {30'b0, state_o}, 32'd3); chk("L_halted_req", {31'b0, imem_req}, 32'd0);
                  chk("L_halted_pc", pc_next, 32'h4); chk("L_halted_cnt", fetch_cnt, 32'd11); end
        19: begin chk("L_rst_state", {30'b0, state_o}, 32'd0); chk("L_rst_pc", pc_next, 32'h0); end
        21: chk("L_rw_fetch", {30'b0, state_o}, 32'd1);
        22: begin chk("L_rw_wait", {30'b0, state_o}, 32'd2); chk("L_rw_req", {31'b0, imem_req}, 32'd1); end
        23, 24: begin chk("L_post_state", {30'b0, state_o}, 32'd0);
                  chk("L_post_valid", {31'b0, instr_valid}, 32'd0); chk("L_post_cnt", fetch_cnt, 32'd0); end
        default: ;
      endcase
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (2) nxt();
    rst = 1'b1; start = 1'b1; tag = 1;
    nxt(); start = 1'b0; tag = 2;
    nxt(); tag = 3;
    nxt(); tag = 4;
    nxt(); tag = 5; jmp = 1'b1; jmp_target = 32'h8;
    nxt(); tag = 6; jmp = 1'b0; imem_ready = 1'b0;
    nxt(); tag = 7;
    nxt(); tag = 8; imem_ready = 1'b1;
    nxt(); tag = 9; imem_ready = 1'b0;
    nxt(); tag = 10; br_taken = 1'b1; br_target = 32'h40;
    nxt(); tag = 11; br_taken = 1'b0; imem_ready = 1'b1;
    nxt(); tag = 12; jmp = 1'b1; jmp_target = 32'h100; br_taken = 1'b1; br_target = 32'h80;
    nxt(); tag = 13; br_taken = 1'b0; jmp_target = 32'hFFFF_FFFC;
    nxt(); tag = 14; jmp = 1'b0;
    nxt(); tag = 15; stall = 1'b1;
    nxt(); tag = 16; stall = 1'b0;
    nxt(); tag = 17; halt_req = 1'b1;
    nxt(); tag = 18; halt_req = 1'b0; start = 1'b1;
    nxt(); tag = 19; start = 1'b0;
    #2 rst = 1'b0;
    nxt(); nxt();
    tag = 20; rst = 1'b1; start = 1'b1; imem_ready = 1'b0;
    nxt(); tag = 21; start = 1'b0;
    nxt(); tag = 22;
    nxt(); tag = 0;
    #2 rst = 1'b0; imem_ready = 1'b1;
    nxt(); tag = 23; rst = 1'b1;
    nxt(); tag = 24;
    nxt(); tag = 0;
    repeat (2) nxt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
